pc_fetch_sequencer: RTL and testbench



---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the PC fetch sequencer.
package pc_seq_pkg;

    localparam int ADDR_W_DEFAULT  = 12;
    localparam int INSTR_W_DEFAULT = 32;
    localparam logic [ADDR_W_DEFAULT-1:0] RESET_ADDR_DEFAULT = 12'h000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_DRAIN,
        S_HALT
    } state_e;

endpackage

// File: rtl/pc_fetch_sequencer.sv
// Drives program_counter's next value and runs the imem fetch / decode issue handshake.
// Optional PC_WRAP_TRAP_EN: incrementing past all-ones raises a sticky fault and halts.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  pc_q,
    output logic [ADDR_W-1:0]  pc_d,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt_req,
    output logic               halted,
    output logic               fault
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic               imem_req_q, imem_req_d;
    logic               instr_valid_q, instr_valid_d;
    logic               halted_q, halted_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               fault_q, fault_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        fault_d    = fault_q;

        case (state_q)
            S_IDLE: begin
                pc_d = RESET_ADDR;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (branch_en) begin
                    pc_d    = branch_target;
                    state_d = imem_ack ? S_DRAIN : S_FETCH;
                end else if (halt_req) begin
                    state_d = S_HALT;
                end else if (imem_ack) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_en) begin
                    pc_d    = branch_target;
                    state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                end else if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (branch_en) begin
                    pc_d    = branch_target;
                    state_d = S_FETCH;
                end else if (instr_ready) begin
`ifdef PC_WRAP_TRAP_EN
                    if (&pc_q) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + PC_ONE;
                        state_d = halt_req ? S_HALT : S_FETCH;
                    end
`else
                    pc_d    = pc_q + PC_ONE;
                    state_d = halt_req ? S_HALT : S_FETCH;
`endif
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) state_d = S_FETCH;
            end
            S_HALT: begin
                if (start && !fault_q) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset must load RESET_ADDR into program_counter on the same edge.
        if (rst) pc_d = RESET_ADDR;

        imem_req_d    = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_ISSUE);
        halted_d      = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fault_q       <= fault_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = halted_q;
`ifdef PC_WRAP_TRAP_EN
    assign fault       = fault_q;
`else
    assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed vector bench for pc_fetch_sequencer with an inline program_counter register.
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] pc_q;
    logic [11:0] pc_d;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [11:0] instr_pc;
    logic        branch_en;
    logic [11:0] branch_target;
    logic        halt_req;
    logic        halted;
    logic        fault;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic        start;
        logic        ack;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        br;
        logic [11:0] tgt;
        logic        halt;
        logic        e_req;
        logic        e_valid;
        logic        e_halted;
        logic        e_fault;
        logic [11:0] e_pc;
        logic [31:0] e_instr;
        logic [11:0] e_ipc;
    } vec_t;

    vec_t vecs[$];

    pc_fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pc_q          (pc_q),
        .pc_d          (pc_d),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .halted        (halted),
        .fault         (fault)
    );

    // program_counter: plain register with no enable
    always_ff @(posedge clk) pc_q <= pc_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic ak, input logic rv,
                                input logic [31:0] rd, input logic rdy, input logic br,
                                input logic [11:0] tg, input logic hl,
                                input logic er, input logic ev, input logic eh, input logic ef,
                                input logic [11:0] ep, input logic [31:0] ei,
                                input logic [11:0] eip);
        vec_t v;
        v.start = st;  v.ack = ak;  v.rvalid = rv;  v.rdata = rd;
        v.ready = rdy; v.br = br;   v.tgt = tg;     v.halt = hl;
        v.e_req = er;  v.e_valid = ev; v.e_halted = eh; v.e_fault = ef;
        v.e_pc = ep;   v.e_instr = ei; v.e_ipc = eip;
        return v;
    endfunction

    task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        start         = v.start;
        imem_ack      = v.ack;
        imem_rvalid   = v.rvalid;
        imem_rdata    = v.rdata;
        instr_ready   = v.ready;
        branch_en     = v.br;
        branch_target = v.tgt;
        halt_req      = v.halt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkOne({tag, ".imem_req"},    {31'd0, imem_req},    {31'd0, v.e_req});
        checkOne({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, v.e_valid});
        checkOne({tag, ".halted"},      {31'd0, halted},      {31'd0, v.e_halted});
        checkOne({tag, ".fault"},       {31'd0, fault},       {31'd0, v.e_fault});
        checkOne({tag, ".pc_q"},        {20'd0, pc_q},        {20'd0, v.e_pc});
        checkOne({tag, ".imem_addr"},   {20'd0, imem_addr},   {20'd0, v.e_pc});
        checkOne({tag, ".instr"},       instr,                v.e_instr);
        checkOne({tag, ".instr_pc"},    {20'd0, instr_pc},    {20'd0, v.e_ipc});
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        start = 0; imem_ack = 0; imem_rvalid = 0; imem_rdata = '0;
        instr_ready = 0; branch_en = 0; branch_target = '0; halt_req = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic wrap_fault;
        logic [11:0] wrap_pc;
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        start = 0; imem_ack = 0; imem_rvalid = 0; imem_rdata = '0;
        instr_ready = 0; branch_en = 0; branch_target = '0; halt_req = 0;

`ifdef PC_WRAP_TRAP_EN
        wrap_fault = 1'b1;
        wrap_pc    = 12'hFFF;
`else
        wrap_fault = 1'b0;
        wrap_pc    = 12'h000;
`endif

        //          st ak rv rdata          rdy br tgt     hl  req vld hlt flt pc      instr          ipc
        vecs.push_back(mk(1,0,0,32'h0,         0,0,12'h000,0,  1,0,0,0, 12'h000, 32'h0,         12'h000));
        vecs.push_back(mk(0,1,0,32'h0,         0,0,12'h000,0,  0,0,0,0, 12'h000, 32'h0,         12'h000));
        vecs.push_back(mk(0,0,1,32'hA5A5_0001, 0,0,12'h000,0,  0,1,0,0, 12'h000, 32'hA5A5_0001, 12'h000));
        vecs.push_back(mk(0,0,0,32'h0,         1,0,12'h000,0,  1,0,0,0, 12'h001, 32'hA5A5_0001, 12'h000));
        vecs.push_back(mk(0,1,0,32'h0,         0,0,12'h000,0,  0,0,0,0, 12'h001, 32'hA5A5_0001, 12'h000));
        vecs.push_back(mk(0,0,1,32'hA5A5_0002, 0,0,12'h000,0,  0,1,0,0, 12'h001, 32'hA5A5_0002, 12'h001));
        vecs.push_back(mk(0,0,0,32'h0,         1,0,12'h000,0,  1,0,0,0, 12'h002, 32'hA5A5_0002, 12'h001));
        vecs.push_back(mk(0,1,0,32'h0,         0,0,12'h000,0,  0,0,0,0, 12'h002, 32'hA5A5_0002, 12'h001));
        vecs.push_back(mk(0,0,1,32'hA5A5_0003, 0,0,12'h000,0,  0,1,0,0, 12'h002, 32'hA5A5_0003, 12'h002));
        vecs.push_back(mk(0,0,0,32'h0,         1,0,12'h000,0,  1,0,0,0, 12'h003, 32'hA5A5_0003, 12'h002));
        // branch in FETCH without ack re-issues at the target
        vecs.push_back(mk(0,0,0,32'h0,         0,1,12'h005,0,  1,0,0,0, 12'h005, 32'hA5A5_0003, 12'h002));
        vecs.push_back(mk(0,1,0,32'h0,         0,0,12'h000,0,  0,0,0,0, 12'h005, 32'hA5A5_0003, 12'h002));
        vecs.push_back(mk(0,0,1,32'hA5A5_0005, 0,0,12'h000,0,  0,1,0,0, 12'h005, 32'hA5A5_0005, 12'h005));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,0,32'h0,     0,0,12'h000,0,  0,1,0,0, 12'h005, 32'hA5A5_0005, 12'h005));
        vecs.push_back(mk(0,0,0,32'h0,         1,0,12'h000,0,  1,0,0,0, 12'h006, 32'hA5A5_0005, 12'h005));
        vecs.push_back(mk(0,1,0,32'h0,         0,0,12'h000,0,  0,0,0,0, 12'h006, 32'hA5A5_0005, 12'h005));
        // branch in WAIT -> DRAIN, late data discarded
        vecs.push_back(mk(0,0,0,32'h0,         0,1,12'h100,0,  0,0,0,0, 12'h100, 32'hA5A5_0005, 12'h005));
        vecs.push_back(mk(0,0,1,32'hDEAD_BEEF, 1,0,12'h000,0,  1,0,0,0, 12'h100, 32'hA5A5_0005, 12'h005));
        vecs.push_back(mk(0,1,0,32'h0,         0,0,12'h000,0,  0,0,0,0, 12'h100, 32'hA5A5_0005, 12'h005));
        vecs.push_back(mk(0,0,1,32'hA5A5_0100, 0,0,12'h000,0,  0,1,0,0, 12'h100, 32'hA5A5_0100, 12'h100));
        // branch and halt together in ISSUE: branch wins
        vecs.push_back(mk(0,0,0,32'h0,         1,1,12'h007,1,  1,0,0,0, 12'h007, 32'hA5A5_0100, 12'h100));
        vecs.push_back(mk(0,1,0,32'h0,         0,0,12'h000,0,  0,0,0,0, 12'h007, 32'hA5A5_0100, 12'h100));
        vecs.push_back(mk(0,0,1,32'hA5A5_0007, 0,0,12'h000,0,  0,1,0,0, 12'h007, 32'hA5A5_0007, 12'h007));
        vecs.push_back(mk(0,0,0,32'h0,         1,0,12'h000,1,  0,0,1,0, 12'h008, 32'hA5A5_0007, 12'h007));
        vecs.push_back(mk(0,0,0,32'h0,         0,1,12'h200,0,  0,0,1,0, 12'h008, 32'hA5A5_0007, 12'h007));
        vecs.push_back(mk(1,0,0,32'h0,         0,0,12'h000,0,  1,0,0,0, 12'h008, 32'hA5A5_0007, 12'h007));
        // wrap at all-ones
        vecs.push_back(mk(0,0,0,32'h0,         0,1,12'hFFF,0,  1,0,0,0, 12'hFFF, 32'hA5A5_0007, 12'h007));
        vecs.push_back(mk(0,1,0,32'h0,         0,0,12'h000,0,  0,0,0,0, 12'hFFF, 32'hA5A5_0007, 12'h007));
        vecs.push_back(mk(0,0,1,32'hA5A5_0FFF, 0,0,12'h000,0,  0,1,0,0, 12'hFFF, 32'hA5A5_0FFF, 12'hFFF));
        vecs.push_back(mk(0,0,0,32'h0,         1,0,12'h000,0,  !wrap_fault,0,wrap_fault,wrap_fault, wrap_pc, 32'hA5A5_0FFF, 12'hFFF));
        vecs.push_back(mk(1,0,0,32'h0,         0,0,12'h000,0,  !wrap_fault,0,wrap_fault,wrap_fault, wrap_pc, 32'hA5A5_0FFF, 12'hFFF));

        doReset();
        v = mk(0,0,0,32'h0, 0,0,12'h000,0, 0,0,0,0, 12'h000, 32'h0, 12'h000);
        checkOutput("reset", v);
        checkOne("reset.pc_d", {20'd0, pc_d}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // halt in FETCH, restart, then reset while WAIT with a late rvalid
        doReset();
        @(negedge clk);
        rst = 1'b0;
        v = mk(1,0,0,32'h0, 0,0,12'h000,0, 1,0,0,0, 12'h000, 32'h0, 12'h000);
        applyStimulus(v); checkOutput("seq.start", v);
        v = mk(0,0,0,32'h0, 0,0,12'h000,1, 0,0,1,0, 12'h000, 32'h0, 12'h000);
        applyStimulus(v); checkOutput("seq.fetch_halt", v);
        v = mk(1,0,0,32'h0, 0,0,12'h000,0, 1,0,0,0, 12'h000, 32'h0, 12'h000);
        applyStimulus(v); checkOutput("seq.restart", v);
        v = mk(0,0,0,32'h0, 0,1,12'h055,0, 1,0,0,0, 12'h055, 32'h0, 12'h000);
        applyStimulus(v); checkOutput("seq.branch", v);
        v = mk(0,1,0,32'h0, 0,0,12'h000,0, 0,0,0,0, 12'h055, 32'h0, 12'h000);
        applyStimulus(v); checkOutput("seq.wait", v);
        @(negedge clk);
        rst = 1'b1;
        v = mk(0,0,0,32'h0, 0,0,12'h000,0, 0,0,0,0, 12'h000, 32'h0, 12'h000);
        applyStimulus(v); checkOutput("seq.rst_in_wait", v);
        @(negedge clk);
        rst = 1'b0;
        v = mk(0,0,1,32'h0BAD_0BAD, 1,0,12'h000,0, 0,0,0,0, 12'h000, 32'h0, 12'h000);
        applyStimulus(v); checkOutput("seq.late_rvalid", v);
        v = mk(0,0,0,32'h0, 0,0,12'h000,0, 0,0,0,0, 12'h000, 32'h0, 12'h000);
        applyStimulus(v); checkOutput("seq.idle_hold", v);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
